// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_port_arbiter_pkg;

  localparam int NUM_PORTS   = 2;
  localparam int DATA_W      = 32;
  localparam int CNT_W       = 8;
  localparam int TIMEOUT_DEF = 255;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LSU   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } port_req_t;

  // On a tie the port that did not win last tie gets the grant.
  function automatic logic arb_pick(input logic [NUM_PORTS-1:0] req, input logic last);
    return (req == 2'b11) ? ~last : req[1];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// 32-bit 2:1 mux used for the shared memory address and write-data buses.
module Mux2to1_32 (
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic        sel,
  output logic [31:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (port 0) and LSU (port 1); one
// transaction at a time, ack/err/rdata returned to the owner in RESP.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we0,
  input  logic              we1,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              sel,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  port_req_t [NUM_PORTS-1:0] preq;
  logic      [NUM_PORTS-1:0] req_v;
  logic      [NUM_PORTS-1:0] we_v;

  assign preq[0] = {req0, we0, addr0, wdata0};
  assign preq[1] = {req1, we1, addr1, wdata1};

  // Bus slot 0 carries the address, slot 1 the write data.
  logic [1:0][DATA_W-1:0] bus0, bus1, bus_y;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign req_v[p] = preq[p].req;
    assign we_v[p]  = preq[p].we;
  end

  assign bus0 = {preq[0].wdata, preq[0].addr};
  assign bus1 = {preq[1].wdata, preq[1].addr};

  state_e                 state_q, state_d;
  logic                   sel_q, sel_d;
  logic                   last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [NUM_PORTS-1:0]   ack_q, ack_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic                   busy_q, busy_d;

  for (genvar g = 0; g < 2; g++) begin : g_mux
    Mux2to1_32 u_mux (
      .in0 (bus0[g]),
      .in1 (bus1[g]),
      .sel (sel_q),
      .out (bus_y[g])
    );
  end

  assign mem_addr  = bus_y[0];
  assign mem_wdata = bus_y[1];

  always_comb begin
    logic win;
    logic we_cur;
    win       = PORT_FETCH;
    we_cur    = we_v[sel_q];
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    ack_d     = '0;
    mem_req_d = 1'b0;
    mem_we_d  = 1'b0;
    busy_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_v) begin
          win       = arb_pick(req_v, last_q);
          sel_d     = win;
          if (&req_v) last_d = win;
          cnt_d     = '0;
          state_d   = ST_ACCESS;
          mem_req_d = 1'b1;
          mem_we_d  = we_v[win];
          busy_d    = 1'b1;
        end
      end
      ST_ACCESS: begin
        busy_d = 1'b1;
        if (mem_ready) begin
          rdata_d       = we_cur ? '0 : mem_rdata;
          ack_d[sel_q]  = 1'b1;
          state_d       = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          // Abort: owner still gets its ack, flagged with err.
          rdata_d       = '0;
          err_d         = 1'b1;
          ack_d[sel_q]  = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          mem_req_d = 1'b1;
          mem_we_d  = we_cur;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= PORT_FETCH;
      last_q    <= PORT_LSU;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      ack_q     <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      ack_q     <= ack_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      busy_q    <= busy_d;
    end
  end

  assign ack0    = ack_q[0];
  assign ack1    = ack_q[1];
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign mem_req = mem_req_q;
  assign mem_we  = mem_we_q;
  assign sel     = sel_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random two-port traffic against a latency-by-address memory; scoreboard per port.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err, mem_req, mem_we, mem_ready, sel, busy;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
    .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .sel(sel), .busy(busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        err;
  } txn_t;

  txn_t exp_q0[$];
  txn_t exp_q1[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory behaviour: data is a hash of the address, wait states are addr[4:2].
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  function automatic int lat_of(input logic [31:0] a);
    return int'(a[4:2]);
  endfunction

  function automatic txn_t mk(input logic [31:0] a, input logic w, input logic [31:0] d);
    txn_t t;
    t.addr  = a;
    t.wdata = d;
    t.we    = w;
    t.err   = (lat_of(a) >= TO);
    t.rdata = (t.err || w) ? 32'h0 : mem_val(a);
    return t;
  endfunction

  task automatic put(input int p, input logic r, input txn_t t);
    if (p == 0) begin
      req0 = r; addr0 = t.addr; wdata0 = t.wdata; we0 = t.we;
    end else begin
      req1 = r; addr1 = t.addr; wdata1 = t.wdata; we1 = t.we;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  task automatic drive(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      txn_t t;
      int   gap;
      int   w;
      logic got;
      gap = (i == 0) ? 0 : $urandom_range(0, 3);
      if (gap > 0) begin
        drop(p);
        repeat (gap) @(posedge clk);
        #1;
      end
      t = mk($urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), $urandom);
      if (p == 0) exp_q0.push_back(t);
      else        exp_q1.push_back(t);
      put(p, 1'b1, t);
      w = 0;
      got = 1'b0;
      while (!got && w < 40) begin
        @(posedge clk);
        #1;
        w++;
        got = (p == 0) ? ack0 : ack1;
      end
      if (!got) begin
        chk($sformatf("ack_wait_p%0d", p), 32'(got), 32'h1);
        break;
      end
    end
    drop(p);
  endtask

  // Memory responder; also raises stray mem_ready whenever no access is active.
  initial begin : memory
    int   k;
    logic in_acc;
    mem_ready = 1'b0;
    mem_rdata = '0;
    in_acc    = 1'b0;
    k         = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (!in_acc) begin in_acc = 1'b1; k = 0; end
        else k++;
        mem_ready = (k == lat_of(mem_addr));
        mem_rdata = mem_ready ? mem_val(mem_addr) : $urandom;
      end else begin
        in_acc    = 1'b0;
        mem_ready = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: arbitration model, bus contents, and ack/rdata/err scoreboard.
  initial begin : monitor
    logic       mr_prev, last_m, sel_prev, active, win, grant;
    logic [1:0] req_prev;
    int         acnt;
    txn_t       cur;
    mr_prev = 0; last_m = 1; sel_prev = 0; active = 0; req_prev = 0; acnt = 0; win = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mr_prev = 0; last_m = 1; sel_prev = 0; active = 0; req_prev = 0;
      end else begin
        grant = mem_req && !mr_prev;
        if (grant) begin
          if (req_prev == 2'b00) begin
            chk("grant_without_req", 32'(req_prev), 32'h1);
          end else begin
            if (req_prev == 2'b11) begin
              win    = ~last_m;
              last_m = win;
            end else begin
              win = req_prev[1];
            end
            chk("grant_sel", 32'(sel), 32'(win));
            if ((win ? exp_q1.size() : exp_q0.size()) == 0) begin
              chk("grant_queue_empty", 32'(win), 32'hFFFF_FFFF);
            end else begin
              cur    = win ? exp_q1[0] : exp_q0[0];
              active = 1'b1;
              acnt   = 0;
            end
          end
        end else begin
          chk("sel_hold", 32'(sel), 32'(sel_prev));
        end
        if (mem_req) begin
          acnt++;
          if (active) begin
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_we", 32'(mem_we), 32'(cur.we));
            chk("mem_wdata", mem_wdata, cur.wdata);
          end
          chk("busy_access", 32'(busy), 32'h1);
        end else begin
          chk("mem_we_idle", 32'(mem_we), 32'h0);
        end
        if (!mem_req && mr_prev && active) begin
          chk("ack_owner", {30'h0, ack1, ack0}, win ? 32'h2 : 32'h1);
          chk("err", 32'(err), 32'(cur.err));
          chk("rdata", rdata, cur.rdata);
          chk("access_cycles", 32'(acnt), cur.err ? 32'(TO) : 32'(lat_of(cur.addr) + 1));
          chk("busy_resp", 32'(busy), 32'h1);
          if (win) void'(exp_q1.pop_front());
          else     void'(exp_q0.pop_front());
          active = 1'b0;
        end else if (!mem_req) begin
          chk("spurious_ack", {30'h0, ack1, ack0}, 32'h0);
          chk("busy_idle", 32'(busy), 32'h0);
        end
        mr_prev  = mem_req;
        req_prev = {req1, req0};
        sel_prev = sel;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin : main
    txn_t t;
    int   w;
    t = mk(32'h0, 1'b0, 32'h0);
    put(0, 1'b0, t);
    put(1, 1'b0, t);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ack", {30'h0, ack1, ack0}, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single fetch read, zero wait states.
    t = mk(32'h0000_0040, 1'b0, 32'h0);
    exp_q0.push_back(t);
    put(0, 1'b1, t);
    @(posedge clk);
    #1;
    chk("t1_mem_addr", mem_addr, 32'h0000_0040);
    chk("t1_mem_req", 32'(mem_req), 32'h1);
    @(posedge clk);
    #1;
    chk("t1_ack0_latency", 32'(ack0), 32'h1);
    chk("t1_rdata", rdata, mem_val(32'h0000_0040));
    chk("t1_err", 32'(err), 32'h0);
    drop(0);
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of an access.
    t = mk(32'h0000_001C, 1'b0, 32'h0);
    exp_q0.push_back(t);
    put(0, 1'b1, t);
    w = 0;
    while (!mem_req && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("rst_mid_granted", 32'(mem_req), 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_ack", {30'h0, ack1, ack0}, 32'h0);
    drop(0);
    exp_q0.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Both ports start together from reset, then random traffic.
    fork
      drive(0, 40);
      drive(1, 40);
    join
    repeat (6) @(posedge clk);
    #1;
    chk("q0_drained", 32'(exp_q0.size()), 32'h0);
    chk("q1_drained", 32'(exp_q1.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the processor's single 32-bit memory port between instruction fetch (port 0) and load/store (port 1). It owns the select line of the 32-bit 2:1 address/write-data muxes in front of memory, sequences one memory transaction at a time with a req/ack handshake, and returns read data and completion to the winning requester. It sits between the fetch/LSU stages and the memory interface of the 32-bit processor.

## Interface
Parameters:
- TIMEOUT, 255: max cycles in ACCESS waiting for mem_ready before abort; 1..255, 8-bit counter.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  transaction request from fetch / LSU; held until ack.
- addr0 / addr1  in  32  byte address; stable while req high.
- wdata0 / wdata1  in  32  write data; stable while req high.
- we0 / we1  in  1  1 = write, 0 = read; stable while req high.
- ack0 / ack1  out  1  one-cycle completion pulse to the owning requester.
- err  out  1  valid with ack; 1 = transaction aborted by timeout.
- rdata  out  32  registered read data; valid in the ack cycle.
- mem_req  out  1  memory access strobe.
- mem_addr  out  32  mux output of addr0/addr1 by sel.
- mem_wdata  out  32  mux output of wdata0/wdata1 by sel.
- mem_we  out  1  we of selected requester, gated by mem_req.
- mem_ready  in  1  memory completes the access this cycle.
- mem_rdata  in  32  memory read data, valid with mem_ready.
- sel  out  1  current owner (0 = fetch, 1 = LSU); drives the muxes.
- busy  out  1  high in ACCESS or RESP.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: no req -> stay. Single req -> sel = that port, counter = 0, go ACCESS. Both req -> grant the port not in `last`; update `last` to winner.
- ACCESS: mem_req = 1, mem_we = selected we. mem_ready -> rdata <= mem_rdata (0 on writes), go RESP. Else counter++; counter == TIMEOUT-1 with no mem_ready -> rdata <= 0, err_pending = 1, go RESP.
- RESP: ack of owner = 1, err = err_pending, mem_req = 0; unconditionally go IDLE, clear err_pending.
- Requester rule: req sampled in the IDLE cycle after ack is treated as a new request (requester must drop or re-present by then).
- mem_ready outside ACCESS ignored. req changes during ACCESS/RESP ignored; loser keeps waiting.
- sel holds its value through IDLE until next grant (no mux toggling on idle).
- Reset values: state IDLE, sel 0, last 1 (port 0 wins first tie), ack0/ack1/err 0, rdata 0, mem_req 0, busy 0, counter 0.
- rst_n low mid-ACCESS: mem_req drops immediately (async), no ack issued; requester re-requests after reset.

## Timing
- Grant decided in IDLE cycle N; mem_req high from N+1.
- mem_ready at ACCESS cycle K -> ack/rdata in K+1; minimum transaction = 3 cycles (IDLE, ACCESS, RESP).
- Timeout: mem_req high exactly TIMEOUT cycles, ack+err in the following cycle.
- Back-to-back with both requesting: strict alternation, one transaction per 3 cycles minimum; no starvation.
- mem_addr/mem_wdata combinational from selected inputs; all other outputs registered.

## Structure
- Shared package: state encodings (IDLE=2'b00, ACCESS=2'b01, RESP=2'b10), PORT_FETCH=0, PORT_LSU=1, default TIMEOUT.
- Sub-module: two instances of existing Mux2to1_32 (address, write data), sel from this block. FSM, counter, rdata register in top.

## Test plan
- Reset then req0=1, addr0=0x0000_0040, mem_ready in first ACCESS cycle with mem_rdata=0xDEAD_BEEF -> mem_addr=0x40, ack0 two cycles after req, rdata=0xDEAD_BEEF, err=0.
- req0 and req1 asserted together from reset -> port 0 served first, then port 1; held both high for 4 transactions -> grants 0,1,0,1.
- req1 write we1=1, addr1=0x100, wdata1=0x1234_5678, mem_ready after 5 wait cycles -> mem_we=1, mem_wdata=0x1234_5678 for 6 cycles, ack1, rdata=0.
- TIMEOUT=4, mem_ready never -> mem_req high exactly 4 cycles, then ack0=1, err=1, rdata=0.
- rst_n low during ACCESS -> mem_req, busy low immediately, no ack; after release, new req0 completes normally.
- Spurious mem_ready in IDLE and RESP, req1 raised mid port-0 ACCESS -> no extra ack, port 1 granted only after port 0 RESP.
